// File: rtl/mem_wait_responder_if.sv
// Memory control bus between the multi-cycle CPU datapath/controller and the
// wait-state memory responder.
interface mem_wait_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  MemRead;
    logic                  MemWrite;
    logic [31:0]           Address;
    logic [DATA_WIDTH-1:0] WriteData;
    logic [DATA_WIDTH-1:0] ReadData;
    logic                  MemReady;
    logic                  MemBusy;
    logic                  MemError;

    modport master (
        output MemRead,
        output MemWrite,
        output Address,
        output WriteData,
        input  ReadData,
        input  MemReady,
        input  MemBusy,
        input  MemError
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  Address,
        input  WriteData,
        output ReadData,
        output MemReady,
        output MemBusy,
        output MemError
    );
endinterface

// File: rtl/mem_wait_responder.sv
// Word-addressed RAM responder: accepts a read or write in IDLE, waits
// WAIT_CYCLES, then commits and pulses MemReady for one cycle.
module mem_wait_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_wait_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                  state_reg, state_next;
    logic [3:0]              count_reg, count_next;
    logic                    op_write_reg, op_write_next;
    logic [ADDR_WIDTH-1:0]   idx_reg, idx_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic                    error_reg, error_next;
    logic [DATA_WIDTH-1:0]   read_data_reg;

    logic [DATA_WIDTH-1:0]   ram [DEPTH];

    logic                    request;
    logic                    illegal;
    logic                    accept;
    logic                    finish;
    logic                    ram_we;
    logic                    unused_addr_bits;

    // High address bits are deliberately dropped so accesses wrap modulo depth.
    assign unused_addr_bits = ^bus.Address[31:ADDR_WIDTH+2];

    assign request = bus.MemRead | bus.MemWrite;
    assign illegal = (bus.MemRead & bus.MemWrite) | (bus.Address[1:0] != 2'b00);
    assign accept  = (state_reg == ST_IDLE) && request && !illegal;
    // The access commits on the edge that leaves WAIT, i.e. WAIT_CYCLES+1 edges
    // after the request edge; WAIT_CYCLES=0 still spends one busy cycle here.
    assign finish  = (state_reg == ST_WAIT) && (count_reg == 4'd0);
    assign ram_we  = finish && op_write_reg;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_WAIT;
            ST_WAIT: if (count_reg == 4'd0) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.MemBusy  = (state_reg == ST_WAIT);
        bus.MemReady = (state_reg == ST_RESP);
        bus.MemError = error_reg;
        bus.ReadData = read_data_reg;
    end

    // Request latches and wait counter
    always_comb begin
        count_next    = count_reg;
        op_write_next = op_write_reg;
        idx_next      = idx_reg;
        wdata_next    = wdata_reg;
        error_next    = (state_reg == ST_IDLE) && request && illegal;
        if (accept) begin
            count_next    = 4'(WAIT_CYCLES);
            op_write_next = bus.MemWrite;
            idx_next      = bus.Address[ADDR_WIDTH+1:2];
            wdata_next    = bus.WriteData;
        end else if ((state_reg == ST_WAIT) && (count_reg != 4'd0)) begin
            count_next = count_reg - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg     <= 4'd0;
            op_write_reg  <= 1'b0;
            idx_reg       <= '0;
            wdata_reg     <= '0;
            error_reg     <= 1'b0;
            read_data_reg <= '0;
        end else begin
            count_reg    <= count_next;
            op_write_reg <= op_write_next;
            idx_reg      <= idx_next;
            wdata_reg    <= wdata_next;
            error_reg    <= error_next;
            if (finish && !op_write_reg) begin
                read_data_reg <= ram[idx_reg];
            end
        end
    end

    // RAM contents survive reset; a reset mid-access forces IDLE, so no write.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[idx_reg] <= wdata_reg;
        end
    end

endmodule
